// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, drives imem, and queues {pc, instr} pairs for decode.
// Optional static redirect of unconditional B at fetch is enabled by defining FETCH_BPRED_EN.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          FQ_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  output logic [63:0]                     imem_addr,
  input  logic [31:0]                     imem_instr,
  input  logic                            id_ready,
  output logic                            if_valid,
  output logic [31:0]                     if_instr,
  output logic [63:0]                     if_pc,
  input  logic                            br_taken,
  input  logic [63:0]                     br_target,
  output logic [$clog2(FQ_DEPTH+1)-1:0]   fq_count
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = $clog2(FQ_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  fq_entry_t        mem [FQ_DEPTH];
  fq_entry_t        head, head_n, new_entry;
  logic [63:0]      pc_q, pc_n, next_pc, seq_pc;
  logic [PTR_W-1:0] rd_ptr, rd_n, wr_ptr, wr_n;
  logic [CNT_W-1:0] count, count_n;
  logic             push, pop;

  assign imem_addr = pc_q;
  assign if_valid  = (count != '0);
  assign if_instr  = head.instr;
  assign if_pc     = head.pc;
  assign fq_count  = count;

  assign pop       = if_valid & id_ready;
  assign push      = ~br_taken & ((count < DEPTH_C) | pop);
  assign new_entry = '{pc: pc_q, instr: imem_instr};
  assign seq_pc    = pc_q + 64'd4;

`ifdef FETCH_BPRED_EN
  // The B is still enqueued; only the fetch stream is steered early.
  assign next_pc = (imem_instr[31:26] == 6'b000101)
                 ? pc_q + {{36{imem_instr[25]}}, imem_instr[25:0], 2'b00}
                 : seq_pc;
`else
  assign next_pc = seq_pc;
`endif

  always_comb begin
    count_n = count;
    rd_n    = rd_ptr;
    wr_n    = wr_ptr;
    head_n  = head;
    pc_n    = pc_q;
    if (br_taken) begin
      count_n = '0;
      rd_n    = '0;
      wr_n    = '0;
      pc_n    = br_target & ~64'h3;
    end else begin
      if (push) begin
        wr_n = wr_ptr + PTR_W'(1);
        pc_n = next_pc;
      end
      if (pop) rd_n = rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_n = count + CNT_W'(1);
        2'b01:   count_n = count - CNT_W'(1);
        default: count_n = count;
      endcase
      // The entry being written this edge is not in mem yet; forward it when it becomes head.
      if (count_n != '0)
        head_n = (push && rd_n == wr_ptr) ? new_entry : mem[rd_n];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      pc_q   <= pc_n;
      rd_ptr <= rd_n;
      wr_ptr <= wr_n;
      count  <= count_n;
      head   <= head_n;
    end
  end

  // NOTE: queue storage is deliberately not reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!reset) count <= DEPTH_C)
    else $error("fetch queue occupancy out of range");

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: table of per-edge vectors plus hand sequences for
// async reset and the fetch-time B redirect (result depends on FETCH_BPRED_EN).
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        br_taken;
  logic [63:0] br_target;
  logic [1:0]  fq_count;
  logic        b_enable;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage #(.RESET_PC(64'h0), .FQ_DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .imem_addr (imem_addr),
    .imem_instr(imem_instr),
    .id_ready  (id_ready),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .br_taken  (br_taken),
    .br_target (br_target),
    .fq_count  (fq_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: word = A000_0000 + addr, with an optional B (imm26 = -4) at 0x20.
  always_comb begin
    imem_instr = 32'hA000_0000 + imem_addr[31:0];
    if (b_enable && imem_addr == 64'h20) imem_instr = 32'h17FF_FFFC;
  end

  typedef struct {
    logic        rdy;
    logic        br;
    logic [63:0] tgt;
    logic        exp_valid;
    logic [63:0] exp_pc;
    logic [1:0]  exp_cnt;
    logic [63:0] exp_addr;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t v(logic rdy, logic br, logic [63:0] tgt, logic ev,
                             logic [63:0] epc, logic [1:0] ecnt, logic [63:0] eaddr);
    vec_t r;
    r.rdy = rdy; r.br = br; r.tgt = tgt; r.exp_valid = ev;
    r.exp_pc = epc; r.exp_cnt = ecnt; r.exp_addr = eaddr;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] exp_after_b;
  bit          found;

  initial begin
    // Streaming, back-pressure, redirect with full queue, redirect over pop, wrap at 2^64.
    vecs[0]  = v(1, 0, 64'h0,   1, 64'h0,   2'd1, 64'h4);
    vecs[1]  = v(1, 0, 64'h0,   1, 64'h4,   2'd1, 64'h8);
    vecs[2]  = v(1, 0, 64'h0,   1, 64'h8,   2'd1, 64'hC);
    vecs[3]  = v(0, 0, 64'h0,   1, 64'h8,   2'd2, 64'h10);
    vecs[4]  = v(0, 0, 64'h0,   1, 64'h8,   2'd2, 64'h10);
    vecs[5]  = v(0, 0, 64'h0,   1, 64'h8,   2'd2, 64'h10);
    vecs[6]  = v(0, 0, 64'h0,   1, 64'h8,   2'd2, 64'h10);
    vecs[7]  = v(0, 0, 64'h0,   1, 64'h8,   2'd2, 64'h10);
    vecs[8]  = v(1, 0, 64'h0,   1, 64'hC,   2'd2, 64'h14);
    vecs[9]  = v(1, 0, 64'h0,   1, 64'h10,  2'd2, 64'h18);
    vecs[10] = v(1, 0, 64'h0,   1, 64'h14,  2'd2, 64'h1C);
    vecs[11] = v(0, 1, 64'h100, 0, 64'h0,   2'd0, 64'h100);
    vecs[12] = v(0, 0, 64'h0,   1, 64'h100, 2'd1, 64'h104);
    vecs[13] = v(0, 0, 64'h0,   1, 64'h100, 2'd2, 64'h108);
    vecs[14] = v(1, 1, 64'h103, 0, 64'h0,   2'd0, 64'h100);
    vecs[15] = v(1, 1, 64'h203, 0, 64'h0,   2'd0, 64'h200);
    vecs[16] = v(1, 0, 64'h0,   1, 64'h200, 2'd1, 64'h204);
    vecs[17] = v(1, 0, 64'h0,   1, 64'h204, 2'd1, 64'h208);
    vecs[18] = v(1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 64'h0, 2'd0, 64'hFFFF_FFFF_FFFF_FFFC);
    vecs[19] = v(1, 0, 64'h0,   1, 64'hFFFF_FFFF_FFFF_FFFC, 2'd1, 64'h0);
    vecs[20] = v(1, 0, 64'h0,   1, 64'h0,   2'd1, 64'h4);

    reset     = 1'b0;
    id_ready  = 1'b1;
    br_taken  = 1'b0;
    br_target = 64'h0;
    b_enable  = 1'b0;
    #12;
    check("reset valid", {63'h0, if_valid}, 64'h0);
    check("reset instr", {32'h0, if_instr}, 64'h0);
    check("reset pc",    if_pc, 64'h0);
    check("reset count", {62'h0, fq_count}, 64'h0);
    check("reset addr",  imem_addr, 64'h0);

    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      id_ready  = vecs[i].rdy;
      br_taken  = vecs[i].br;
      br_target = vecs[i].tgt;
      step();
      check($sformatf("v%0d valid", i), {63'h0, if_valid}, {63'h0, vecs[i].exp_valid});
      check($sformatf("v%0d count", i), {62'h0, fq_count}, {62'h0, vecs[i].exp_cnt});
      check($sformatf("v%0d addr", i),  imem_addr, vecs[i].exp_addr);
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d pc", i), if_pc, vecs[i].exp_pc);
        check($sformatf("v%0d instr", i), {32'h0, if_instr},
              {32'h0, 32'hA000_0000 + vecs[i].exp_pc[31:0]});
      end
    end
    br_taken = 1'b0;
    id_ready = 1'b1;

    // Async reset between edges: outputs clear without waiting for a clock.
    #2 reset = 1'b0;
    #1;
    check("async valid", {63'h0, if_valid}, 64'h0);
    check("async instr", {32'h0, if_instr}, 64'h0);
    check("async pc",    if_pc, 64'h0);
    check("async count", {62'h0, fq_count}, 64'h0);
    check("async addr",  imem_addr, 64'h0);
    #2 reset = 1'b1;
    b_enable = 1'b1;
    step();
    check("resume valid", {63'h0, if_valid}, 64'h1);
    check("resume pc",    if_pc, 64'h0);
    check("resume addr",  imem_addr, 64'h4);

    // Stream until the B at 0x20 reaches the head, then look at what follows it.
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (if_valid && if_pc == 64'h20) found = 1'b1;
      else step();
    end
    check("b reached head", {63'h0, found}, 64'h1);
    check("b head instr", {32'h0, if_instr}, {32'h0, 32'h17FF_FFFC});
`ifdef FETCH_BPRED_EN
    exp_after_b = 64'h10;
`else
    exp_after_b = 64'h24;
`endif
    step();
    check("after b pc", if_pc, exp_after_b);
    check("after b valid", {63'h0, if_valid}, 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
